// File: rtl/mem_bist_pkg.sv
// Shared definitions for the 8x16 RAM march-test initiator: state and phase
// encodings, geometry, the read-compare record and the pattern helpers.
package mem_bist_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ST_W   = 3;
    localparam int unsigned PH_W   = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ERR_W  = 5;

    // March states are encoded in execution order; the FSM steps by +1.
    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_CLR     = 3'd1;
    localparam logic [ST_W-1:0] ST_RD_ZERO = 3'd2;
    localparam logic [ST_W-1:0] ST_WR_P    = 3'd3;
    localparam logic [ST_W-1:0] ST_RD_P    = 3'd4;
    localparam logic [ST_W-1:0] ST_WR_N    = 3'd5;
    localparam logic [ST_W-1:0] ST_RD_N    = 3'd6;
    localparam logic [ST_W-1:0] ST_DONE    = 3'd7;

    localparam logic [PH_W-1:0] PH_NONE    = 2'd0;
    localparam logic [PH_W-1:0] PH_RD_ZERO = 2'd1;
    localparam logic [PH_W-1:0] PH_RD_P    = 2'd2;
    localparam logic [PH_W-1:0] PH_RD_N    = 2'd3;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] expected;
        logic [PH_W-1:0]   phase;
    } rd_entry_t;

    // Per-address word: base rotated left by the address.
    function automatic logic [DATA_W-1:0] rotl_pattern(
        input logic [DATA_W-1:0] base,
        input logic [ADDR_W-1:0] a
    );
        logic [2*DATA_W-1:0] w;
        w = {base, base} << a;
        return w[2*DATA_W-1:DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] expected_word(
        input logic [PH_W-1:0]   ph,
        input logic [DATA_W-1:0] base,
        input logic [ADDR_W-1:0] a
    );
        logic [DATA_W-1:0] w;
        case (ph)
            PH_RD_P: w = rotl_pattern(base, a);
            PH_RD_N: w = ~rotl_pattern(base, a);
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic [PH_W-1:0] state_phase(input logic [ST_W-1:0] st);
        logic [PH_W-1:0] ph;
        case (st)
            ST_RD_ZERO: ph = PH_RD_ZERO;
            ST_RD_P:    ph = PH_RD_P;
            ST_RD_N:    ph = PH_RD_N;
            default:    ph = PH_NONE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/bist_rd_pipe.sv
// RD_LAT-deep delay line aligning each issued read with its returning data.
module bist_rd_pipe
    import mem_bist_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  rd_entry_t i_entry,
    output rd_entry_t o_entry
);

    rd_entry_t [RD_LAT-1:0] r_stage;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_entry;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_entry = r_stage[RD_LAT-1];

endmodule

// File: rtl/mem_bist_8x16.sv
// March-test initiator for the 8x16 dual-port RAM: clear, read 0, write/read
// pattern, write/read inverse; reports pass, error count and first failure.
module mem_bist_8x16
    import mem_bist_pkg::*;
#(
    parameter logic [DATA_W-1:0] PATTERN = 16'hA5C3,
    parameter int unsigned       RD_LAT  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ERR_W-1:0]  o_err_count,
    output logic [PH_W-1:0]   o_fail_phase,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [DATA_W-1:0] o_fail_data,
    output logic              o_ram_rst,
    output logic              o_we,
    output logic              o_en,
    output logic [ADDR_W-1:0] o_addr_w,
    output logic [ADDR_W-1:0] o_addr_r,
    output logic [DATA_W-1:0] o_data_w,
    input  logic [DATA_W-1:0] i_data_r
);

    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(DEPTH + RD_LAT - 1);

    logic [ST_W-1:0]   r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_pass, w_pass_nxt;
    logic [ERR_W-1:0]  r_err_count, w_err_count_nxt;
    logic [PH_W-1:0]   r_fail_phase, w_fail_phase_nxt;
    logic [ADDR_W-1:0] r_fail_addr, w_fail_addr_nxt;
    logic [DATA_W-1:0] r_fail_data, w_fail_data_nxt;
    logic              r_ram_rst, w_ram_rst_nxt;
    logic              r_we, w_we_nxt;
    logic              r_en, w_en_nxt;
    logic [ADDR_W-1:0] r_addr_w, w_addr_w_nxt;
    logic [ADDR_W-1:0] r_addr_r, w_addr_r_nxt;
    logic [DATA_W-1:0] r_data_w, w_data_w_nxt;

    logic              w_accept;
    logic              w_mismatch;
    logic              w_rd_state_nxt;
    rd_entry_t         w_pipe_in;
    rd_entry_t         w_pipe_out;

    // Record of the read issued this cycle, compared RD_LAT edges later.
    always_comb begin
        w_pipe_in = '0;
        if (r_en) begin
            w_pipe_in.valid    = 1'b1;
            w_pipe_in.addr     = r_addr_r;
            w_pipe_in.phase    = state_phase(r_state);
            w_pipe_in.expected = expected_word(state_phase(r_state), PATTERN, r_addr_r);
        end
    end

    bist_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_entry (w_pipe_in),
        .o_entry (w_pipe_out)
    );

    assign w_accept   = (r_state == ST_IDLE) && i_start;
    assign w_mismatch = w_pipe_out.valid && (i_data_r != w_pipe_out.expected);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state plus the RAM-port and result values registered at the edge.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_pass_nxt       = r_pass;
        w_err_count_nxt  = r_err_count;
        w_fail_phase_nxt = r_fail_phase;
        w_fail_addr_nxt  = r_fail_addr;
        w_fail_data_nxt  = r_fail_data;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_CLR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CLR: begin
                w_state_nxt = ST_RD_ZERO;
                w_cnt_nxt   = '0;
            end
            ST_RD_ZERO, ST_RD_P, ST_RD_N: begin
                if (r_cnt == RD_LAST) begin
                    w_state_nxt = r_state + ST_W'(1);
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WR_P, ST_WR_N: begin
                if (r_cnt == WR_LAST) begin
                    w_state_nxt = r_state + ST_W'(1);
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        w_rd_state_nxt = (w_state_nxt == ST_RD_ZERO) || (w_state_nxt == ST_RD_P) ||
                         (w_state_nxt == ST_RD_N);
        w_ram_rst_nxt  = (w_state_nxt == ST_CLR);
        w_we_nxt       = (w_state_nxt == ST_WR_P) || (w_state_nxt == ST_WR_N);
        w_en_nxt       = w_rd_state_nxt && (w_cnt_nxt < CNT_W'(DEPTH));
        w_addr_w_nxt   = w_we_nxt ? w_cnt_nxt[ADDR_W-1:0] : '0;
        w_addr_r_nxt   = w_en_nxt ? w_cnt_nxt[ADDR_W-1:0] : '0;
        w_busy_nxt     = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
        w_done_nxt     = (w_state_nxt == ST_DONE);

        case (w_state_nxt)
            ST_WR_P: w_data_w_nxt = rotl_pattern(PATTERN, w_cnt_nxt[ADDR_W-1:0]);
            ST_WR_N: w_data_w_nxt = ~rotl_pattern(PATTERN, w_cnt_nxt[ADDR_W-1:0]);
            default: w_data_w_nxt = '0;
        endcase

        if (w_accept) begin
            w_pass_nxt       = 1'b0;
            w_err_count_nxt  = '0;
            w_fail_phase_nxt = PH_NONE;
            w_fail_addr_nxt  = '0;
            w_fail_data_nxt  = '0;
        end else if (w_mismatch) begin
            w_err_count_nxt = r_err_count + ERR_W'(1);
            if (r_fail_phase == PH_NONE) begin
                w_fail_phase_nxt = w_pipe_out.phase;
                w_fail_addr_nxt  = w_pipe_out.addr;
                w_fail_data_nxt  = i_data_r;
            end
        end

        // Last compare lands on the edge entering DONE, so use the updated count.
        if (w_state_nxt == ST_DONE) begin
            w_pass_nxt = (w_err_count_nxt == '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_fail_phase <= PH_NONE;
            r_fail_addr  <= '0;
            r_fail_data  <= '0;
            r_ram_rst    <= 1'b0;
            r_we         <= 1'b0;
            r_en         <= 1'b0;
            r_addr_w     <= '0;
            r_addr_r     <= '0;
            r_data_w     <= '0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_err_count  <= w_err_count_nxt;
            r_fail_phase <= w_fail_phase_nxt;
            r_fail_addr  <= w_fail_addr_nxt;
            r_fail_data  <= w_fail_data_nxt;
            r_ram_rst    <= w_ram_rst_nxt;
            r_we         <= w_we_nxt;
            r_en         <= w_en_nxt;
            r_addr_w     <= w_addr_w_nxt;
            r_addr_r     <= w_addr_r_nxt;
            r_data_w     <= w_data_w_nxt;
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_count  = r_err_count;
    assign o_fail_phase = r_fail_phase;
    assign o_fail_addr  = r_fail_addr;
    assign o_fail_data  = r_fail_data;
    assign o_ram_rst    = r_ram_rst;
    assign o_we         = r_we;
    assign o_en         = r_en;
    assign o_addr_w     = r_addr_w;
    assign o_addr_r     = r_addr_r;
    assign o_data_w     = r_data_w;

endmodule

// File: tb/tb_mem_bist_8x16.sv
// Bench for mem_bist_8x16: RAM models with injectable stuck-at cell, directed
// and randomized runs checked against a march-level reference model.
module tb_mem_bist_8x16;

    localparam logic [15:0] PAT = 16'hA5C3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sel   = 1'b0;
    logic start1, start2;
    assign start1 = start & ~sel;
    assign start2 = start & sel;

    logic        busy1, done1, pass1, rr1, we1, en1;
    logic [4:0]  err1;
    logic [1:0]  fph1;
    logic [2:0]  fad1, aw1, ar1;
    logic [15:0] fda1, dw1, dr1;
    logic        busy2, done2, pass2, rr2, we2, en2;
    logic [4:0]  err2;
    logic [1:0]  fph2;
    logic [2:0]  fad2, aw2, ar2;
    logic [15:0] fda2, dw2, dr2;

    mem_bist_8x16 #(.PATTERN(PAT), .RD_LAT(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_count(err1),
        .o_fail_phase(fph1), .o_fail_addr(fad1), .o_fail_data(fda1),
        .o_ram_rst(rr1), .o_we(we1), .o_en(en1), .o_addr_w(aw1), .o_addr_r(ar1),
        .o_data_w(dw1), .i_data_r(dr1)
    );

    mem_bist_8x16 #(.PATTERN(PAT), .RD_LAT(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2),
        .o_busy(busy2), .o_done(done2), .o_pass(pass2), .o_err_count(err2),
        .o_fail_phase(fph2), .o_fail_addr(fad2), .o_fail_data(fda2),
        .o_ram_rst(rr2), .o_we(we2), .o_en(en2), .o_addr_w(aw2), .o_addr_r(ar2),
        .o_data_w(dw2), .i_data_r(dr2)
    );

    logic [53:0] all1, all2;
    assign all1 = {busy1, done1, pass1, err1, fph1, fad1, fda1, rr1, we1, en1, aw1, ar1, dw1};
    assign all2 = {busy2, done2, pass2, err2, fph2, fad2, fda2, rr2, we2, en2, aw2, ar2, dw2};

    logic        m_busy, m_done, m_pass, m_we, m_en;
    logic [4:0]  m_err;
    logic [1:0]  m_fph;
    logic [2:0]  m_fad, m_aw, m_ar;
    logic [15:0] m_fda;
    assign m_busy = sel ? busy2 : busy1;
    assign m_done = sel ? done2 : done1;
    assign m_pass = sel ? pass2 : pass1;
    assign m_we   = sel ? we2   : we1;
    assign m_en   = sel ? en2   : en1;
    assign m_err  = sel ? err2  : err1;
    assign m_fph  = sel ? fph2  : fph1;
    assign m_fad  = sel ? fad2  : fad1;
    assign m_aw   = sel ? aw2   : aw1;
    assign m_ar   = sel ? ar2   : ar1;
    assign m_fda  = sel ? fda2  : fda1;

    // Stuck-at cell injected into the RD_LAT=1 RAM model.
    bit f_on = 1'b0;
    int f_addr = 0;
    int f_bit = 0;
    bit f_val = 1'b0;

    function automatic logic [15:0] fap(input logic [15:0] d, input int a);
        logic [15:0] mask;
        mask = 16'h1 << f_bit;
        if (f_on && a == f_addr) return f_val ? (d | mask) : (d & ~mask);
        return d;
    endfunction

    function automatic logic [15:0] pword(input int a);
        logic [31:0] t;
        t = {16'h0, PAT};
        t = ((t << a) | (t >> (16 - a))) & 32'hFFFF;
        return t[15:0];
    endfunction

    logic [15:0] mem1 [8];
    logic [15:0] rd1;
    logic [15:0] mem2 [8];
    logic [15:0] rd2a, rd2b;
    logic [15:0] wr3_prev, wr3_last;
    int wr3_cnt = 0;
    int conflict = 0;
    int rst_acc = 0;

    always @(posedge clk) begin
        if (!rst_n) for (int i = 0; i < 8; i++) mem1[i] <= 16'hFFFF;
        else if (rr1) for (int i = 0; i < 8; i++) mem1[i] <= 16'h0;
        else if (we1) mem1[aw1] <= dw1;
        if (en1) rd1 <= fap(mem1[ar1], int'(ar1));
        if (we1 && aw1 == 3'd3) begin
            wr3_prev <= wr3_last;
            wr3_last <= dw1;
            wr3_cnt  <= wr3_cnt + 1;
        end
    end
    assign dr1 = rd1;

    always @(posedge clk) begin
        if (!rst_n) for (int i = 0; i < 8; i++) mem2[i] <= 16'hFFFF;
        else if (rr2) for (int i = 0; i < 8; i++) mem2[i] <= 16'h0;
        else if (we2) mem2[aw2] <= dw2;
        if (en2) rd2a <= mem2[ar2];
        rd2b <= rd2a;
    end
    assign dr2 = rd2b;

    always @(posedge clk) begin
        if ((we1 && en1) || (we2 && en2)) conflict <= conflict + 1;
        if (!rst_n && (we1 || en1 || rr1 || we2 || en2 || rr2)) rst_acc <= rst_acc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // March-level reference: every phase reads back what the previous phase stored.
    function automatic void ref_model(output int err, output int ph, output int ad, output int dat);
        logic [15:0] ex, ob;
        err = 0; ph = 0; ad = 0; dat = 0;
        for (int p = 1; p <= 3; p++) begin
            for (int a = 0; a < 8; a++) begin
                ex = (p == 1) ? 16'h0 : (p == 2) ? pword(a) : ~pword(a);
                ob = fap(ex, a);
                if (ob != ex) begin
                    err++;
                    if (ph == 0) begin ph = p; ad = a; dat = int'(ob); end
                end
            end
        end
    endfunction

    // Expected RAM-port activity in cycle k+n of a run with latency L.
    function automatic void exp_ctrl(input int n, input int L, output bit we, output bit en,
                                     output int aw, output int ar);
        int lens[6];
        int s, off;
        lens[0] = 1; lens[1] = 8 + L; lens[2] = 8; lens[3] = 8 + L; lens[4] = 8; lens[5] = 8 + L;
        we = 0; en = 0; aw = 0; ar = 0; s = 1;
        for (int p = 0; p < 6; p++) begin
            if (n >= s && n < s + lens[p]) begin
                off = n - s;
                if (p == 2 || p == 4) begin we = 1; aw = off; end
                if ((p == 1 || p == 3 || p == 5) && off < 8) begin en = 1; ar = off; end
            end
            s += lens[p];
        end
    endfunction

    task automatic run(input bit s, input int resend, input int abort,
                       output int dcyc, output int ndone);
        int L, seq_bad, aw, ar;
        bit ew, ee, eb;
        L = s ? 2 : 1;
        seq_bad = 0;
        sel = s;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcyc = -1;
        ndone = 0;
        for (int n = 1; n <= 70; n++) begin
            if (m_done) begin
                ndone++;
                if (dcyc < 0) dcyc = n;
            end
            if (abort == 0 || n < abort) begin
                exp_ctrl(n, L, ew, ee, aw, ar);
                eb = (n <= 41 + 3 * L);
                if (m_busy !== eb || m_we !== ew || m_en !== ee ||
                    m_aw !== 3'(aw) || m_ar !== 3'(ar)) seq_bad++;
            end
            if (n == resend) start = 1'b1;
            if (n == resend + 1) start = 1'b0;
            if (n == abort) begin
                rst_n = 1'b0;
                #1;
                chk("abort_busy", 32'(m_busy), 0);
                chk("abort_we", 32'(m_we), 0);
                chk("abort_en", 32'(m_en), 0);
            end
            if (abort > 0 && n == abort + 3) rst_n = 1'b1;
            @(posedge clk);
            #1;
        end
        if (abort == 0) chk("ctrl_seq", 32'(seq_bad), 0);
    endtask

    int dc, nd, r_err, r_ph, r_ad, r_dat, wbase;

    initial begin
        // Reset held with start asserted: everything quiet.
        start = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("rst_hold_dut1", 32'(|all1), 0);
            chk("rst_hold_dut2", 32'(|all2), 0);
        end
        start = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy1), 0);
        chk("idle_outputs", 32'(|all1), 0);
        chk("rst_ram_access", 32'(rst_acc), 0);

        // Good RAM, RD_LAT=1.
        wbase = wr3_cnt;
        run(1'b0, 0, 0, dc, nd);
        chk("good_done_cycle", 32'(dc), 45);
        chk("good_done_count", 32'(nd), 1);
        chk("good_pass", 32'(pass1), 1);
        chk("good_err", 32'(err1), 0);
        chk("good_fail_phase", 32'(fph1), 0);
        chk("wr3_count", 32'(wr3_cnt - wbase), 2);
        chk("wr_p_addr3", 32'(wr3_prev), 32'h2E1D);
        chk("wr_n_addr3", 32'(wr3_last), 32'hD1E2);

        // Address 5 bit 0 stuck at 0: only the inverse read sees it.
        f_on = 1'b1; f_addr = 5; f_bit = 0; f_val = 1'b0;
        run(1'b0, 0, 0, dc, nd);
        chk("sa0_done_cycle", 32'(dc), 45);
        chk("sa0_err", 32'(err1), 1);
        chk("sa0_fail_phase", 32'(fph1), 3);
        chk("sa0_fail_addr", 32'(fad1), 5);
        chk("sa0_fail_data", 32'(fda1), 32'h478A);
        chk("sa0_pass", 32'(pass1), 0);

        // Start re-asserted mid-run is ignored.
        f_on = 1'b0;
        run(1'b0, 10, 0, dc, nd);
        chk("resend_done_count", 32'(nd), 1);
        chk("resend_done_cycle", 32'(dc), 45);
        chk("resend_pass", 32'(pass1), 1);

        // Reset mid-run aborts without done; next run is clean.
        run(1'b0, 0, 20, dc, nd);
        chk("abort_no_done", 32'(nd), 0);
        chk("abort_err_zero", 32'(err1), 0);
        chk("abort_pass_zero", 32'(pass1), 0);
        run(1'b0, 0, 0, dc, nd);
        chk("rerun_done_cycle", 32'(dc), 45);
        chk("rerun_pass", 32'(pass1), 1);
        chk("rerun_err", 32'(err1), 0);

        // Randomized stuck-at cells against the reference model.
        repeat (8) begin
            f_on   = 1'($urandom_range(0, 3) != 0);
            f_addr = int'($urandom_range(0, 7));
            f_bit  = int'($urandom_range(0, 15));
            f_val  = 1'($urandom_range(0, 1));
            ref_model(r_err, r_ph, r_ad, r_dat);
            run(1'b0, 0, 0, dc, nd);
            chk("rand_done_cycle", 32'(dc), 45);
            chk("rand_err", 32'(err1), 32'(r_err));
            chk("rand_fail_phase", 32'(fph1), 32'(r_ph));
            chk("rand_fail_addr", 32'(fad1), 32'(r_ad));
            chk("rand_fail_data", 32'(fda1), 32'(r_dat));
            chk("rand_pass", 32'(pass1), 32'(r_err == 0));
        end
        f_on = 1'b0;

        // RD_LAT=2 instance with a two-cycle RAM.
        run(1'b1, 0, 0, dc, nd);
        chk("lat2_done_cycle", 32'(dc), 48);
        chk("lat2_done_count", 32'(nd), 1);
        chk("lat2_pass", 32'(pass2), 1);
        chk("lat2_err", 32'(err2), 0);

        chk("we_en_conflict", 32'(conflict), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
